square_bcd_converter: RTL and testbench



---
 rtl/square_bcd_converter_if.sv | 13 +
 rtl/square_bcd_converter.sv | 65 ++++++
 tb/tb_square_bcd_converter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/square_bcd_converter_if.sv
// square_bcd_converter_if: request/result bundle between the square generator, the BCD converter and the display stage.
interface square_bcd_converter_if;
    logic       start;
    logic [5:0] sq_in;
    logic       busy;
    logic       done;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       is_sq;

    modport master (output start, sq_in, input busy, done, tens, ones, is_sq);
    modport slave (input start, sq_in, output busy, done, tens, ones, is_sq);
endinterface

// File: rtl/square_bcd_converter.sv
// square_bcd_converter: 6-bit square word to two BCD digits by double-dabble, plus a perfect-square flag.
module square_bcd_converter (
    input logic                   clk,
    input logic                   rst,
    square_bcd_converter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state, w_next;
    logic [13:0] r_scr, w_scr;
    logic [2:0]  r_cnt;
    logic [5:0]  r_cap;
    logic [3:0]  r_tens, r_ones, w_t, w_o;
    logic        r_is_sq, w_is_sq, w_last;

    // Both nibbles are corrected on pre-shift values before the common shift.
    always_comb begin
        w_t = r_scr[13:10] >= 4'd5 ? r_scr[13:10] + 4'd3 : r_scr[13:10];
        w_o = r_scr[9:6] >= 4'd5 ? r_scr[9:6] + 4'd3 : r_scr[9:6];
        w_scr = {w_t, w_o, r_scr[5:0]} << 1;
        w_last = r_cnt == 3'd5;
        w_is_sq = r_cap inside {6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_is_sq <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_scr <= {8'd0, bus.sq_in};
                r_cap <= bus.sq_in;
                r_cnt <= '0;
            end
            if (r_state == SHIFT) begin
                r_scr <= w_scr;
                r_cnt <= r_cnt + 3'd1;
            end
            // Results are published only on the final iteration, so outputs never show scratch values.
            if (r_state == SHIFT && w_last) begin
                r_tens  <= w_scr[13:10];
                r_ones  <= w_scr[9:6];
                r_is_sq <= w_is_sq;
            end
        end
    end

    assign bus.busy  = r_state != IDLE;
    assign bus.done  = r_state == DONE;
    assign bus.tens  = r_tens;
    assign bus.ones  = r_ones;
    assign bus.is_sq = r_is_sq;
endmodule

// File: tb/tb_square_bcd_converter.sv
// tb_square_bcd_converter: directed stimulus with a scoreboard queue drained by an independent done monitor.
module tb_square_bcd_converter;
    typedef struct {
        int t;
        int o;
        int s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t q[$];

    square_bcd_converter_if bus ();
    square_bcd_converter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            n_done++;
            chk("busy_with_done", int'(bus.busy), 1);
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("tens", int'(bus.tens), e.t);
                chk("ones", int'(bus.ones), e.o);
                chk("is_sq", int'(bus.is_sq), e.s);
            end
        end
    end

    task automatic do_conv(input int v, input int t, input int o, input int s);
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        bus.start = 1'b1;
        bus.sq_in = 6'(v);
        q.push_back('{t, o, s});
        @(negedge clk);
        bus.start = 1'b0;
        bus.sq_in = 6'($urandom);
        chk("busy_after_e0", int'(bus.busy), 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("done_latency", int'(bus.done), int'(i == 6));
        end
        @(negedge clk);
        chk("busy_after_e7", int'(bus.busy), 0);
        chk("tens_hold", int'(bus.tens), t);
        chk("ones_hold", int'(bus.ones), o);
    endtask

    initial begin
        int n0, last, pulses;
        bit stable;
        bus.start = 1'b1;
        bus.sq_in = 6'd49;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_tens", int'(bus.tens), 0);
        chk("rst_ones", int'(bus.ones), 0);
        chk("rst_is_sq", int'(bus.is_sq), 0);
        rst = 1'b0;
        bus.start = 1'b0;

        do_conv(49, 4, 9, 1);
        do_conv(0, 0, 0, 1);
        do_conv(1, 0, 1, 1);
        do_conv(4, 0, 4, 1);
        do_conv(9, 0, 9, 1);
        do_conv(16, 1, 6, 1);
        do_conv(25, 2, 5, 1);
        do_conv(36, 3, 6, 1);
        do_conv(49, 4, 9, 1);
        do_conv(63, 6, 3, 0);
        do_conv(50, 5, 0, 0);

        // A start pulse during SHIFT must be dropped, not queued.
        @(negedge clk);
        n0 = n_done;
        bus.start = 1'b1;
        bus.sq_in = 6'd25;
        q.push_back('{2, 5, 1});
        @(negedge clk);
        bus.start = 1'b0;
        bus.sq_in = 6'd0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.sq_in = 6'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_start_done_count", n_done - n0, 1);
        repeat (3) @(negedge clk);
        chk("ignored_start_no_accept", int'(bus.busy), 0);
        chk("ignored_start_done_total", n_done - n0, 1);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        n0 = n_done;
        bus.start = 1'b1;
        bus.sq_in = 6'd36;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_tens", int'(bus.tens), 0);
        chk("abort_ones", int'(bus.ones), 0);
        chk("abort_is_sq", int'(bus.is_sq), 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_done - n0, 0);
        do_conv(16, 1, 6, 1);

        // Continuous start gives one conversion every 8 cycles.
        @(negedge clk);
        for (int i = 0; i < 4; i++) q.push_back('{0, 4, 1});
        bus.start = 1'b1;
        bus.sq_in = 6'd4;
        last = -1;
        pulses = 0;
        stable = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last >= 0) chk("period", i - last, 8);
                else chk("first_done_index", i, 7);
                last = i;
                pulses++;
            end else if (last >= 0) begin
                stable &= (bus.tens == 4'd0) && (bus.ones == 4'd4);
            end
        end
        bus.start = 1'b0;
        chk("hold_pulses", pulses, 4);
        chk("hold_stable", int'(stable), 1);
        repeat (3) @(negedge clk);
        chk("hold_idle", int'(bus.busy), 0);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
